// File: rtl/mem_stage.sv
// MEM pipeline stage: word loads/stores to a local data memory with a fixed
// multi-cycle access latency, registered into the MEM latch for writeback.
module mem_stage #(
  parameter int DBITS       = 32,
  parameter int DMEM_WORDS  = 1024,
  parameter int MEM_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DBITS-1:0] in_pc,
  input  logic [31:0]      in_inst,
  input  logic             in_is_load,
  input  logic             in_is_store,
  input  logic             in_wr_reg,
  input  logic [4:0]       in_reg_dest,
  input  logic [DBITS-1:0] in_result,
  input  logic [DBITS-1:0] in_mem_addr,
  input  logic [DBITS-1:0] in_store_data,
  output logic             stall_out,
  output logic             out_valid,
  output logic [DBITS-1:0] out_pc,
  output logic [31:0]      out_inst,
  output logic             out_wr_reg,
  output logic [4:0]       out_reg_dest,
  output logic [DBITS-1:0] out_value,
  output logic             out_misalign,
  output logic             fwd_wr_reg,
  output logic [4:0]       fwd_reg_dest,
  output logic [DBITS-1:0] fwd_value
);

  localparam int IDX_W = $clog2(DMEM_WORDS);
  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_stage: MEM_LATENCY must be at least 1");
  end
  if (DMEM_WORDS < 2 || (1 << IDX_W) != DMEM_WORDS) begin : g_bad_depth
    $error("mem_stage: DMEM_WORDS must be a power of two >= 2");
  end
  if (DBITS < IDX_W + 2) begin : g_bad_width
    $error("mem_stage: DBITS too narrow to address DMEM_WORDS");
  end

  logic [DBITS-1:0] mem [DMEM_WORDS];

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [DBITS-1:0] pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic             wr_reg_q, wr_reg_d;
  logic [4:0]       reg_dest_q, reg_dest_d;
  logic [DBITS-1:0] value_q, value_d;
  logic             misalign_q, misalign_d;

  logic             is_mem;
  logic             misaligned;
  logic             mem_go;
  logic             at_last;
  logic             stall;
  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [DBITS-1:0] rd_data;

  assign is_mem     = in_is_load | in_is_store;
  assign misaligned = is_mem & (in_mem_addr[1:0] != 2'b00);
  assign mem_go     = in_valid & is_mem & ~misaligned;
  assign at_last    = (cnt_q == CNT_LAST);
  // Reset forces the stage idle, so no stall is requested while it is held.
  assign stall      = mem_go & ~at_last & ~reset;
  assign mem_we     = mem_go & at_last & in_is_store & ~reset;
  assign mem_idx    = in_mem_addr[IDX_W+1:2];
  assign rd_data    = mem[mem_idx];

  // Upper address bits are intentionally dropped so addresses wrap.
  if (DBITS > IDX_W + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^in_mem_addr[DBITS-1:IDX_W+2];
  end

  always_comb begin
    cnt_d      = '0;
    valid_d    = 1'b0;
    pc_d       = '0;
    inst_d     = '0;
    wr_reg_d   = 1'b0;
    reg_dest_d = '0;
    value_d    = '0;
    misalign_d = 1'b0;

    if (stall) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (in_valid && !stall) begin
      valid_d    = 1'b1;
      pc_d       = in_pc;
      inst_d     = in_inst;
      reg_dest_d = in_reg_dest;
      if (misaligned) begin
        misalign_d = 1'b1;
      end else if (in_is_store) begin
        value_d = in_store_data;
      end else if (in_is_load) begin
        wr_reg_d = in_wr_reg;
        value_d  = rd_data;
      end else begin
        wr_reg_d = in_wr_reg;
        value_d  = in_result;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      pc_q       <= '0;
      inst_q     <= '0;
      wr_reg_q   <= 1'b0;
      reg_dest_q <= '0;
      value_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      wr_reg_q   <= wr_reg_d;
      reg_dest_q <= reg_dest_d;
      value_q    <= value_d;
      misalign_q <= misalign_d;
    end
  end

  // Contents survive reset; only the write enable is gated by it.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= in_store_data;
    end
  end

  assign stall_out    = stall;
  assign out_valid    = valid_q;
  assign out_pc       = pc_q;
  assign out_inst     = inst_q;
  assign out_wr_reg   = wr_reg_q;
  assign out_reg_dest = reg_dest_q;
  assign out_value    = value_q;
  assign out_misalign = misalign_q;
  assign fwd_wr_reg   = valid_q & wr_reg_q;
  assign fwd_reg_dest = reg_dest_q;
  assign fwd_value    = value_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of address-generation/execute. It consumes that stage's latched result, performs word loads and stores to a local data memory with a configurable multi-cycle access latency, and registers results into the MEM latch for writeback.
- Stalls upstream while an access is in flight.
- Exports the latched destination and value to decode for hazard detection and forwarding.

Parameters:
- DBITS, 32, data/address width.
- DMEM_WORDS, 1024, data memory depth in 32-bit words (power of two).
- MEM_LATENCY, 2, cycles per load/store access (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream latch holds a real instruction.
- in_pc  in  DBITS  PC of incoming instruction.
- in_inst  in  32  instruction word.
- in_is_load  in  1  op is LW.
- in_is_store  in  1  op is SW.
- in_wr_reg  in  1  instruction writes rd.
- in_reg_dest  in  5  rd index.
- in_result  in  DBITS  ALU result / link value (non-memory ops).
- in_mem_addr  in  DBITS  effective address.
- in_store_data  in  DBITS  SW data.
- stall_out  out  1  upstream must hold its latch this cycle.
- out_valid  out  1  MEM latch valid.
- out_pc  out  DBITS  latched PC.
- out_inst  out  32  latched instruction.
- out_wr_reg  out  1  latched write enable.
- out_reg_dest  out  5  latched rd.
- out_value  out  DBITS  load data or pass-through result.
- out_misalign  out  1  latched misaligned-access flag.
- fwd_wr_reg  out  1  equals out_valid & out_wr_reg.
- fwd_reg_dest  out  5  equals out_reg_dest.
- fwd_value  out  DBITS  equals out_value.

Behaviour:
- **Reset.** On reset, all out_* latch fields are 0, the access counter is 0, and stall_out=0. Memory contents are not cleared. Reset mid-access aborts it: no write occurs and no latch update happens other than clearing.
- **Latch.** The output latch is a single register updated every clock edge.
- **Non-memory op** (in_valid & !is_load & !is_store):
  - Single cycle, no stall.
  - Next edge: out_valid=1, out_value=in_result, other fields copied.
- **Bubble** (in_valid=0): next edge out_valid=0 and out_wr_reg=0.
- **Memory op counter.** A counter cnt, width clog2(MEM_LATENCY) (min 1), tracks cycles spent on the current access.
  - stall_out = in_valid & (is_load|is_store) & !misaligned & (cnt != MEM_LATENCY-1). This is combinational.
  - While stall_out=1: cnt increments at each edge, and the latch captures a bubble (out_valid=0, out_wr_reg=0).
  - Completion cycle (cnt==MEM_LATENCY-1): at the edge, a store writes mem[idx]=in_store_data and a load captures out_value=mem[idx]. The latch captures the instruction with out_valid=1, and cnt returns to 0.
  - Net effect: a memory op occupies the stage for MEM_LATENCY cycles. With MEM_LATENCY=1 there is no stall.
- **Upstream contract.** Upstream holds all in_* stable while stall_out=1. Inputs that change mid-access are undefined behaviour; benches must not do this.
- **Addressing.** idx = in_mem_addr[clog2(DMEM_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DMEM_WORDS*4.
- **Misaligned access** (in_mem_addr[1:0]!=0 on load/store):
  - No stall and no memory write.
  - Next edge: out_valid=1, out_misalign=1, out_wr_reg=0, out_value=0.
- **Store latch fields.** Stores latch out_wr_reg=0 regardless of in_wr_reg.
- **Same-address ordering.** A load completing at the same index as the previous store's completion reads the newly written value. The write happens at the earlier edge, so there is no bypass logic.
- **Reads and writes per edge.** At most one memory read or write per edge. There is no write-during-read conflict because only one op is in the stage.
- **Forwarding.** fwd_* are taken purely from the latch, with no combinational path from in_*.

Test Plan:
1. **Reset.** Hold reset 2 cycles with in_valid=1 and an ADD (in_result=5) -> all out_* are 0 and stall_out=0. The first edge after reset deasserts latches out_value=5, out_valid=1.
2. **SW then LW, MEM_LATENCY=2.** SW addr=0x10, data=0xDEADBEEF -> stall_out=1 for 1 cycle, then out_valid=1 and out_wr_reg=0. Next, LW addr=0x10, rd=7 -> after 1 stall cycle: out_value=0xDEADBEEF, fwd_wr_reg=1, fwd_reg_dest=7.
3. **Wrap-around.** SW addr=0x1000 (DMEM_WORDS=1024), data=0x1234; then LW addr=0x0 -> out_value=0x1234.
4. **Misaligned.** LW addr=0x13 -> stall_out=0, next edge out_misalign=1, out_wr_reg=0. A subsequent aligned LW of 0x10 returns the unchanged old data.
5. **Reset mid-access.** SW addr=0x20, data=0x55 with MEM_LATENCY=3; assert reset at cnt=1 -> after reset, LW 0x20 returns the prior contents, not 0x55.
6. **Back-to-back and pass-through.** MEM_LATENCY=1, LW/ADD/LW stream -> no stall cycles, out_valid=1 on 3 consecutive edges with correct values.
